// File: rtl/cbus_mem_responder_pkg.sv
// Shared cache-bus types and the burst address helper used by the memory responder and the caches.
package common;

  typedef logic [63:0] addr_t;
  typedef logic [63:0] word_t;
  typedef logic [7:0]  strobe_t;
  typedef logic [7:0]  mlen_t;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED    = 2'd0,
    AXI_BURST_INCR     = 2'd1,
    AXI_BURST_WRAP     = 2'd2,
    AXI_BURST_RESERVED = 2'd3
  } axi_burst_type_t;

  // len encodes beats-1, so MLEN16 is 15
  localparam mlen_t MLEN1  = 8'd0;
  localparam mlen_t MLEN2  = 8'd1;
  localparam mlen_t MLEN4  = 8'd3;
  localparam mlen_t MLEN8  = 8'd7;
  localparam mlen_t MLEN16 = 8'd15;

  typedef struct packed {
    logic            valid;
    logic            is_write;
    msize_t          size;
    addr_t           addr;
    strobe_t         strobe;
    word_t           data;
    mlen_t           len;
    axi_burst_type_t burst;
  } cbus_req_t;

  typedef struct packed {
    logic  ready;
    logic  last;
    word_t data;
  } cbus_resp_t;

  // Word offset of a beat; len (= n-1) doubles as the wrap mask for power-of-2 bursts.
  function automatic logic [63:0] burst_index(input logic [63:0] w0, input mlen_t beat,
                                              input mlen_t len, input axi_burst_type_t burst);
    logic [63:0] mask;
    logic [63:0] idx;
    mask = {56'd0, len};
    case (burst)
      AXI_BURST_INCR: idx = w0 + {56'd0, beat};
      AXI_BURST_WRAP: idx = (w0 & ~mask) | ((w0 + {56'd0, beat}) & mask);
      default:        idx = w0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/cbus_mem_responder_array.sv
// Word storage for the responder: byte-strobed synchronous write, combinational read, never cleared.
module cbus_mem_array
  import common::*;
#(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic                         clk,
  input  logic                         i_we,
  input  logic [$clog2(MEM_WORDS)-1:0] i_waddr,
  input  strobe_t                      i_strobe,
  input  word_t                        i_wdata,
  input  logic [$clog2(MEM_WORDS)-1:0] i_raddr,
  output word_t                        o_rdata
);

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      logic [7:0] r_lane [MEM_WORDS];

      always_ff @(posedge clk) begin
        if (i_we && i_strobe[gi]) begin
          r_lane[i_waddr] <= i_wdata[gi*8 +: 8];
        end
      end

      assign o_rdata[gi*8 +: 8] = r_lane[i_raddr];
    end
  endgenerate

endmodule

// File: rtl/cbus_mem_responder.sv
// Cache-bus memory responder: single and FIXED/INCR/WRAP burst reads and writes against on-chip storage.
module cbus_mem_responder
  import common::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
  parameter int unsigned LATENCY   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp
);

  localparam int unsigned IDX_W     = $clog2(MEM_WORDS);
  localparam logic [15:0] WAIT_INIT = (LATENCY > 1) ? 16'(LATENCY - 2) : 16'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

  state_t          r_state, w_state_next;
  mlen_t           r_beat, w_beat_next;
  logic [15:0]     r_wait, w_wait_next;
  addr_t           r_addr, w_addr_next;
  mlen_t           r_len, w_len_next;
  axi_burst_type_t r_burst, w_burst_next;
  logic            r_is_write, w_is_write_next;
  logic            r_ready, w_ready_next;
  logic            r_last, w_last_next;
  word_t           r_data, w_data_next;
  logic            w_enter;

  addr_t           w_rd_addr;
  mlen_t           w_rd_len;
  mlen_t           w_rd_beat;
  axi_burst_type_t w_rd_burst;
  logic [63:0]     w_rd_word;
  logic [63:0]     w_wr_word;
  word_t           w_mem_rdata;
  word_t           w_rd_data;
  logic            w_we;
  logic            w_unused;

  function automatic logic [63:0] word_of(input addr_t addr, input mlen_t beat,
                                          input mlen_t len, input axi_burst_type_t burst);
    addr_t offs;
    offs = addr - BASE_ADDR;
    return burst_index({3'b000, offs[63:3]}, beat, len, burst);
  endfunction

  function automatic logic word_ok(input addr_t addr, input logic [63:0] w);
    return (addr >= BASE_ADDR) && (w < 64'(MEM_WORDS));
  endfunction

  // The read port always looks up the beat that will be presented after the next edge.
  always_comb begin
    if (r_state == S_IDLE) begin
      w_rd_addr  = creq.addr;
      w_rd_len   = creq.len;
      w_rd_burst = creq.burst;
      w_rd_beat  = '0;
    end else begin
      w_rd_addr  = r_addr;
      w_rd_len   = r_len;
      w_rd_burst = r_burst;
      w_rd_beat  = (r_state == S_BURST) ? mlen_t'(r_beat + 8'd1) : '0;
    end
  end

  assign w_rd_word = word_of(w_rd_addr, w_rd_beat, w_rd_len, w_rd_burst);
  assign w_rd_data = word_ok(w_rd_addr, w_rd_word) ? w_mem_rdata : '0;
  assign w_wr_word = word_of(r_addr, r_beat, r_len, r_burst);
  assign w_we      = (r_state == S_BURST) && creq.valid && r_is_write && word_ok(r_addr, w_wr_word);
  assign w_unused  = ^creq.size;

  always_comb begin
    w_state_next    = r_state;
    w_beat_next     = r_beat;
    w_wait_next     = r_wait;
    w_addr_next     = r_addr;
    w_len_next      = r_len;
    w_burst_next    = r_burst;
    w_is_write_next = r_is_write;
    w_ready_next    = 1'b0;
    w_last_next     = 1'b0;
    w_data_next     = '0;
    w_enter         = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (creq.valid) begin
          w_addr_next     = creq.addr;
          w_len_next      = creq.len;
          w_burst_next    = creq.burst;
          w_is_write_next = creq.is_write;
          w_beat_next     = '0;
          if (LATENCY == 1) begin
            w_enter = 1'b1;
          end else begin
            w_state_next = S_WAIT;
            w_wait_next  = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (!creq.valid) begin
          w_state_next = S_IDLE;
        end else if (r_wait == 16'd0) begin
          w_enter = 1'b1;
        end else begin
          w_wait_next = r_wait - 16'd1;
        end
      end
      S_BURST: begin
        if (!creq.valid || (r_beat == r_len)) begin
          w_state_next = S_IDLE;
        end else begin
          w_beat_next  = mlen_t'(r_beat + 8'd1);
          w_ready_next = 1'b1;
          w_last_next  = (w_beat_next == r_len);
          w_data_next  = r_is_write ? '0 : w_rd_data;
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    if (w_enter) begin
      w_state_next = S_BURST;
      w_beat_next  = '0;
      w_ready_next = 1'b1;
      w_last_next  = (w_len_next == '0);
      w_data_next  = w_is_write_next ? '0 : w_rd_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_beat     <= '0;
      r_wait     <= '0;
      r_addr     <= '0;
      r_len      <= '0;
      r_burst    <= AXI_BURST_FIXED;
      r_is_write <= 1'b0;
      r_ready    <= 1'b0;
      r_last     <= 1'b0;
      r_data     <= '0;
    end else begin
      r_state    <= w_state_next;
      r_beat     <= w_beat_next;
      r_wait     <= w_wait_next;
      r_addr     <= w_addr_next;
      r_len      <= w_len_next;
      r_burst    <= w_burst_next;
      r_is_write <= w_is_write_next;
      r_ready    <= w_ready_next;
      r_last     <= w_last_next;
      r_data     <= w_data_next;
    end
  end

  assign cresp.ready = r_ready;
  assign cresp.last  = r_last;
  assign cresp.data  = r_data;

  cbus_mem_array #(
    .MEM_WORDS(MEM_WORDS)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_wr_word[IDX_W-1:0]),
    .i_strobe(creq.strobe),
    .i_wdata (creq.data),
    .i_raddr (w_rd_word[IDX_W-1:0]),
    .o_rdata (w_mem_rdata)
  );

endmodule

// File: tb/tb_cbus_mem_responder.sv
// Randomized and directed bench for cbus_mem_responder with a scoreboard queue and an array memory model.
module tb_cbus_mem_responder;
  import common::*;

  localparam int          MEM_WORDS = 1024;
  localparam int          LATENCY   = 1;
  localparam logic [63:0] BASE      = 64'h0000_0000_8000_0000;

  logic       clk = 1'b0;
  logic       reset;
  cbus_req_t  creq;
  cbus_resp_t cresp;

  always #5 clk = ~clk;

  cbus_mem_responder #(
    .MEM_WORDS(MEM_WORDS),
    .BASE_ADDR(BASE),
    .LATENCY  (LATENCY)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .creq (creq),
    .cresp(cresp)
  );

  typedef struct {
    logic  last;
    word_t data;
    int    txn;
    int    beat;
  } exp_t;

  exp_t    expq[$];
  word_t   ref_mem[MEM_WORDS];
  word_t   tx_data[256];
  strobe_t tx_strb[256];
  int      n_checks = 0;
  int      n_fail   = 0;
  int      txn_id   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Reference word lookup straight from the addressing rules (division/modulo, not masks).
  function automatic bit ref_word(input addr_t addr, input int beat, input int len,
                                  input int burst, output int idx);
    longint unsigned w0, n, w;
    idx = 0;
    if (addr < BASE) return 1'b0;
    w0 = (addr - BASE) / 8;
    n  = longint'(len) + 1;
    case (burst)
      1:       w = w0 + longint'(beat);
      2:       w = (w0 / n) * n + (w0 + longint'(beat)) % n;
      default: w = w0;
    endcase
    if (w >= MEM_WORDS) return 1'b0;
    idx = int'(w);
    return 1'b1;
  endfunction

  function automatic word_t merge(input word_t old, input word_t d, input strobe_t s);
    word_t r;
    r = old;
    for (int k = 0; k < 8; k++) if (s[k]) r[k*8 +: 8] = d[k*8 +: 8];
    return r;
  endfunction

  // Monitor: every ready beat is matched against the head of the scoreboard queue.
  always @(negedge clk) begin
    exp_t e;
    if (cresp.ready) begin
      if (expq.size() == 0) begin
        check("unexpected_ready", 64'(cresp.ready), 64'd0);
      end else begin
        e = expq.pop_front();
        check($sformatf("t%0d_b%0d_data", e.txn, e.beat), cresp.data, e.data);
        check($sformatf("t%0d_b%0d_last", e.txn, e.beat), 64'(cresp.last), 64'(e.last));
      end
    end else begin
      check("idle_data", cresp.data, 64'd0);
      check("idle_last", 64'(cresp.last), 64'd0);
    end
  end

  task automatic run_txn(input logic wr, input addr_t addr, input mlen_t len,
                         input axi_burst_type_t burst, input int abort_beat, input bit by_reset);
    int n, cyc, idx;
    n = int'(len) + 1;
    txn_id++;
    $display("txn %0d: %s addr=%h beats=%0d burst=%0d abort=%0d%s", txn_id, wr ? "WR" : "RD",
             addr, n, burst, abort_beat, by_reset ? " (reset)" : "");
    @(negedge clk);
    creq.valid    = 1'b1;
    creq.is_write = wr;
    creq.size     = MSIZE8;
    creq.addr     = addr;
    creq.len      = len;
    creq.burst    = burst;
    creq.data     = tx_data[0];
    creq.strobe   = tx_strb[0];
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.last = (i == n - 1);
      e.txn  = txn_id;
      e.beat = i;
      e.data = '0;
      if (!wr && ref_word(addr, i, int'(len), int'(burst), idx)) e.data = ref_mem[idx];
      expq.push_back(e);
    end
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!cresp.ready && cyc < 50);
    check("first_ready_latency", 64'(cyc), 64'(LATENCY));
    if (!cresp.ready) begin
      expq.delete();
      creq.valid = 1'b0;
      return;
    end
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        @(negedge clk);
        creq.data   = tx_data[i];
        creq.strobe = tx_strb[i];
        check($sformatf("t%0d_b%0d_ready_run", txn_id, i), 64'(cresp.ready), 64'd1);
      end
      if (i == abort_beat) begin
        #2;
        expq.delete();
        if (by_reset) begin
          reset = 1'b0;
          #1;
          check("rst_ready", 64'(cresp.ready), 64'd0);
          check("rst_last", 64'(cresp.last), 64'd0);
          check("rst_data", cresp.data, 64'd0);
          creq.valid = 1'b0;
          @(negedge clk);
          reset = 1'b1;
        end else begin
          creq.valid = 1'b0;
          @(negedge clk);
          check("abort_ready", 64'(cresp.ready), 64'd0);
        end
        return;
      end
      if (wr && ref_word(addr, i, int'(len), int'(burst), idx))
        ref_mem[idx] = merge(ref_mem[idx], tx_data[i], tx_strb[i]);
    end
    @(negedge clk);
    creq.valid = 1'b0;
    check($sformatf("t%0d_ready_drop", txn_id), 64'(cresp.ready), 64'd0);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int      sel, lsel;
    mlen_t   len;
    addr_t   a;
    logic    wr;

    creq  = '0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready", 64'(cresp.ready), 64'd0);
    check("reset_last", 64'(cresp.last), 64'd0);
    check("reset_data", cresp.data, 64'd0);
    reset = 1'b1;

    // Give every word a known value
    for (int blk = 0; blk < 64; blk++) begin
      for (int i = 0; i < 16; i++) begin
        tx_data[i] = {$urandom, $urandom};
        tx_strb[i] = 8'hFF;
      end
      run_txn(1'b1, BASE + 64'(blk * 128), MLEN16, AXI_BURST_INCR, -1, 1'b0);
    end

    tx_data[0] = 64'h1122_3344_5566_7788;
    tx_strb[0] = 8'hFF;
    run_txn(1'b1, BASE + 64'h10, MLEN1, AXI_BURST_INCR, -1, 1'b0);
    run_txn(1'b0, BASE + 64'h10, MLEN1, AXI_BURST_INCR, -1, 1'b0);

    for (int i = 0; i < 16; i++) begin
      tx_data[i] = 64'(i);
      tx_strb[i] = 8'hFF;
    end
    run_txn(1'b1, BASE, MLEN16, AXI_BURST_INCR, -1, 1'b0);
    run_txn(1'b0, BASE, MLEN16, AXI_BURST_INCR, -1, 1'b0);
    run_txn(1'b0, BASE + 64'h18, MLEN4, AXI_BURST_WRAP, -1, 1'b0);

    tx_data[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    tx_strb[0] = 8'hFF;
    run_txn(1'b1, BASE, MLEN1, AXI_BURST_INCR, -1, 1'b0);
    tx_data[0] = 64'hAAAA_BBBB_CCCC_DDDD;
    tx_strb[0] = 8'h0F;
    run_txn(1'b1, BASE, MLEN1, AXI_BURST_INCR, -1, 1'b0);
    run_txn(1'b0, BASE, MLEN1, AXI_BURST_INCR, -1, 1'b0);

    run_txn(1'b0, 64'h0000_1000, MLEN4, AXI_BURST_INCR, -1, 1'b0);
    tx_data[0] = 64'hDEAD_BEEF_0BAD_F00D;
    tx_strb[0] = 8'hFF;
    run_txn(1'b1, 64'h0000_1000, MLEN1, AXI_BURST_INCR, -1, 1'b0);
    run_txn(1'b0, BASE, MLEN16, AXI_BURST_INCR, -1, 1'b0);

    for (int i = 0; i < 16; i++) begin
      tx_data[i] = {32'hC0DE_0000, 32'(i)};
      tx_strb[i] = 8'hFF;
    end
    run_txn(1'b1, BASE, MLEN16, AXI_BURST_INCR, 5, 1'b1);
    run_txn(1'b0, BASE, MLEN16, AXI_BURST_INCR, -1, 1'b0);
    run_txn(1'b0, BASE + 64'h28, MLEN1, AXI_BURST_INCR, -1, 1'b0);

    run_txn(1'b1, BASE + 64'h100, MLEN8, AXI_BURST_INCR, 2, 1'b0);
    run_txn(1'b0, BASE + 64'h100, MLEN8, AXI_BURST_INCR, -1, 1'b0);

    for (int t = 0; t < 80; t++) begin
      sel  = int'($urandom_range(0, 7));
      lsel = int'($urandom_range(0, 4));
      case (lsel)
        0:       len = MLEN1;
        1:       len = MLEN2;
        2:       len = MLEN4;
        3:       len = MLEN8;
        default: len = MLEN16;
      endcase
      if (sel == 0)
        a = 64'($urandom_range(0, 32'h7FFF_FFFF));
      else if (sel == 1)
        a = BASE + 64'($urandom_range(1010, 1100)) * 64'd8 + 64'($urandom_range(0, 7));
      else
        a = BASE + 64'($urandom_range(0, 1023)) * 64'd8 + 64'($urandom_range(0, 7));
      wr = 1'($urandom_range(0, 1));
      for (int i = 0; i < 16; i++) begin
        tx_data[i] = {$urandom, $urandom};
        tx_strb[i] = 8'($urandom_range(0, 255));
      end
      run_txn(wr, a, len, axi_burst_type_t'($urandom_range(0, 3)), -1, 1'b0);
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(expq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
